// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample widths, clock ratios, recorder states and frame payload.
package i2s_pkg;

  localparam int unsigned WIDTH              = 16;
  localparam int unsigned ADDR_W             = 17;
  localparam int unsigned MAIN_TO_LEFT_RIGHT = 1536;
  localparam int unsigned MAIN_TO_BIT        = MAIN_TO_LEFT_RIGHT / (2 * WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RECORD,
    DRAIN
  } rec_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_frame_sync.sv
// Detects completed stereo frames on ws falling edges and latches the L/R pair
// two cycles later, once the receiver outputs have settled.
module i2s_frame_sync
  import i2s_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ws,
  input  logic [WIDTH-1:0] rx_data_l,
  input  logic [WIDTH-1:0] rx_data_r,
  output logic             frame_rdy,
  output stereo_frame_t    frame
);

  logic ws_d;
  logic fall_d1;
  logic fall_d2;
  logic ws_fall_c;

  assign ws_fall_c = ws_d & ~ws;

  // Edge detect, two-cycle settle delay and frame latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_d      <= 1'b0;
      fall_d1   <= 1'b0;
      fall_d2   <= 1'b0;
      frame_rdy <= 1'b0;
      frame     <= '0;
    end else begin
      ws_d      <= ws;
      fall_d1   <= ws_fall_c;
      fall_d2   <= fall_d1;
      frame_rdy <= fall_d2;
      if (fall_d2) begin
        frame.left  <= rx_data_l;
        frame.right <= rx_data_r;
      end
    end
  end

endmodule

// File: rtl/i2s_record_ctrl.sv
// Recording sequencer: captures stereo frames and writes them to track memory
// at consecutive addresses, with stop/drain handling and overrun reporting.
module i2s_record_ctrl
  import i2s_pkg::*;
(
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic                 ws,
  input  logic [WIDTH-1:0]     rx_data_l,
  input  logic [WIDTH-1:0]     rx_data_r,
  input  logic                 arm,
  input  logic                 stop,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    rec_len,
  output logic                 wr_req,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [2*WIDTH-1:0]   wr_data,
  input  logic                 wr_ack,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    frame_cnt,
  output logic                 overrun
);

  rec_state_t          state;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   len;
  logic                frame_rdy;
  stereo_frame_t       frame;
  logic                ack_c;
  logic [ADDR_W-1:0]   cnt_inc_c;
  logic [ADDR_W-1:0]   cnt_eff_c;

  i2s_frame_sync u_frame_sync (
    .clk       (mclk),
    .rst_n     (rst_n),
    .ws        (ws),
    .rx_data_l (rx_data_l),
    .rx_data_r (rx_data_r),
    .frame_rdy (frame_rdy),
    .frame     (frame)
  );

  // An ack only counts against a pending write; cnt_eff_c is the count after this cycle
  assign ack_c     = wr_req & wr_ack;
  assign cnt_inc_c = frame_cnt + ADDR_W'(1);
  assign cnt_eff_c = ack_c ? cnt_inc_c : frame_cnt;

  // Take sequencing, memory write handshake and status outputs
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            base      <= base_addr;
            len       <= rec_len;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            if (rec_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (frame_rdy) begin
            wr_data <= frame;
            wr_addr <= base + frame_cnt;
            wr_req  <= 1'b1;
            state   <= RECORD;
          end
        end
        RECORD: begin
          if (ack_c) begin
            frame_cnt <= cnt_inc_c;
          end
          if (ack_c && (cnt_inc_c == len)) begin
            wr_req <= 1'b0;
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (stop) begin
            if (wr_req && !ack_c) begin
              state <= DRAIN;
            end else begin
              wr_req <= 1'b0;
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else if (frame_rdy) begin
            if (!wr_req || ack_c) begin
              wr_data <= frame;
              wr_addr <= base + cnt_eff_c;
              wr_req  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (ack_c) begin
            wr_req <= 1'b0;
          end
        end
        DRAIN: begin
          if (ack_c) begin
            frame_cnt <= cnt_inc_c;
            wr_req    <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_record_ctrl.sv
// Scoreboard bench for i2s_record_ctrl: an I2S source model, directed takes,
// and a monitor that pops expected writes on every memory handshake.
module tb_i2s_record_ctrl;
  import i2s_pkg::*;

  localparam int H = 8;  // mclk cycles per ws half

  logic               mclk = 1'b0;
  logic               rst_n;
  logic               ws;
  logic [WIDTH-1:0]   rx_data_l;
  logic [WIDTH-1:0]   rx_data_r;
  logic               arm;
  logic               stop;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  rec_len;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [2*WIDTH-1:0] wr_data;
  logic               wr_ack;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  frame_cnt;
  logic               overrun;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [2*WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cur_frame = 0;

  i2s_record_ctrl dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .ws        (ws),
    .rx_data_l (rx_data_l),
    .rx_data_r (rx_data_r),
    .arm       (arm),
    .stop      (stop),
    .base_addr (base_addr),
    .rec_len   (rec_len),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
  );

  always #5 mclk = ~mclk;

  function automatic logic [WIDTH-1:0] lval(input int n);
    return 16'hA000 + WIDTH'(n);
  endfunction

  function automatic logic [WIDTH-1:0] rval(input int n);
    return 16'h5000 + WIDTH'(n);
  endfunction

  function automatic logic [2*WIDTH-1:0] fval(input int n);
    return {lval(n), rval(n)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input int n);
    exp_t e;
    e.addr = a;
    e.data = fval(n);
    exp_q.push_back(e);
  endtask

  // I2S source: left sample appears one cycle after ws rises, right one cycle after ws falls
  initial begin
    int ph;
    ph = 0;
    ws = 1'b0;
    rx_data_l = '0;
    rx_data_r = '0;
    forever begin
      @(posedge mclk);
      #1;
      ph = (ph + 1) % (2 * H);
      if (ph == H) ws = 1'b1;
      if (ph == H + 1) rx_data_l = lval(cur_frame);
      if (ph == 0) begin
        ws = 1'b0;
        cur_frame++;
      end
      if (ph == 1) rx_data_r = rval(cur_frame - 1);
    end
  end

  // Monitor: handshake scoreboard, hold stability and done pulse shape
  initial begin
    exp_t e;
    logic done_prev = 1'b0;
    logic req_prev = 1'b0;
    logic hs_prev = 1'b0;
    logic [ADDR_W-1:0] addr_prev = '0;
    logic [2*WIDTH-1:0] data_prev = '0;
    forever begin
      @(negedge mclk);
      if (!rst_n) begin
        done_prev = 1'b0;
        req_prev  = 1'b0;
        hs_prev   = 1'b0;
      end else begin
        if (done) begin
          chk("done_one_cycle", 64'(done_prev), 64'd0);
          chk("busy_low_at_done", 64'(busy), 64'd0);
          done_cnt++;
        end
        if (wr_req && req_prev && !hs_prev) begin
          chk("wr_addr_hold", 64'(wr_addr), 64'(addr_prev));
          chk("wr_data_hold", 64'(wr_data), 64'(data_prev));
        end
        if (wr_req && wr_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e.addr));
            chk("wr_data", 64'(wr_data), 64'(e.data));
          end
        end
        done_prev = done;
        req_prev  = wr_req;
        hs_prev   = wr_req & wr_ack;
        addr_prev = wr_addr;
        data_prev = wr_data;
      end
    end
  end

  // Wait for ws to move to lvl, then step to the middle of the new half
  task automatic wait_half_mid(input logic lvl);
    logic p;
    bit seen;
    p = ws;
    seen = 1'b0;
    for (int i = 0; i < 8 * H; i++) begin
      @(negedge mclk);
      if (p == ~lvl && ws == lvl) begin
        seen = 1'b1;
        break;
      end
      p = ws;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ws_edge_timeout: ws stuck at %0b, wanted edge to %0b", ws, lvl);
    end
    repeat (4) @(posedge mclk);
    #1;
  endtask

  task automatic do_arm(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    base_addr = b;
    rec_len   = l;
    arm       = 1'b1;
    @(posedge mclk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge mclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wr_req"}, 64'(wr_req), 64'd0);
    chk({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({name, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({name, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  // Directed takes
  initial begin
    int n;
    bit req_seen;
    rst_n = 1'b0;
    arm = 1'b0;
    stop = 1'b0;
    wr_ack = 1'b0;
    base_addr = '0;
    rec_len = '0;
    repeat (3) @(negedge mclk);
    chk_reset_outputs("reset");
    @(posedge mclk);
    #1;
    rst_n = 1'b1;

    // Basic take, armed mid right half, ack tied high
    wr_ack = 1'b1;
    wait_half_mid(1'b1);
    n = cur_frame;
    for (int i = 0; i < 4; i++) push_exp(17'h00100 + 17'(i), n + i);
    do_arm(17'h00100, 17'd4);
    wait_done("basic_done", 40 * H);
    chk("basic_frame_cnt", 64'(frame_cnt), 64'd4);
    chk("basic_overrun", 64'(overrun), 64'd0);

    // Arm in the middle of a left half: first write is the frame in progress
    wait_half_mid(1'b0);
    n = cur_frame;
    push_exp(17'h00020, n);
    push_exp(17'h00021, n + 1);
    do_arm(17'h00020, 17'd2);
    wait_done("midframe_done", 40 * H);
    chk("midframe_frame_cnt", 64'(frame_cnt), 64'd2);

    // Backpressure during the second frame
    wait_half_mid(1'b0);
    n = cur_frame;
    push_exp(17'h00200, n);
    push_exp(17'h00201, n + 1);
    do_arm(17'h00200, 17'd3);
    wait_half_mid(1'b0);
    repeat (4) @(posedge mclk);
    #1;
    wr_ack = 1'b0;
    repeat (2000) @(posedge mclk);
    @(negedge mclk);
    chk("bp_wr_req", 64'(wr_req), 64'd1);
    chk("bp_wr_data", 64'(wr_data), 64'(fval(n + 1)));
    chk("bp_wr_addr", 64'(wr_addr), 64'h201);
    chk("bp_overrun", 64'(overrun), 64'd1);
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd1);
    wait_half_mid(1'b0);
    push_exp(17'h00202, cur_frame);
    wr_ack = 1'b1;
    wait_done("bp_done", 40 * H);
    chk("bp_frame_cnt_end", 64'(frame_cnt), 64'd3);
    chk("bp_overrun_end", 64'(overrun), 64'd1);

    // Early stop with a write pending, drained by a late ack
    wr_ack = 1'b0;
    wait_half_mid(1'b0);
    n = cur_frame;
    push_exp(17'h00300, n);
    do_arm(17'h00300, 17'd5);
    wait_half_mid(1'b0);
    repeat (2) @(posedge mclk);
    #1;
    stop = 1'b1;
    @(posedge mclk);
    #1;
    stop = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_wr_req", 64'(wr_req), 64'd1);
    repeat (9) @(posedge mclk);
    #1;
    wr_ack = 1'b1;
    wait_done("drain_done", 20);
    chk("drain_frame_cnt", 64'(frame_cnt), 64'd1);
    repeat (5 * H) @(posedge mclk);
    #1;
    chk("drain_no_more_req", 64'(wr_req), 64'd0);
    chk("drain_overrun", 64'(overrun), 64'd0);

    // Address wrap at the top of memory
    wait_half_mid(1'b0);
    n = cur_frame;
    push_exp(17'h1FFFE, n);
    push_exp(17'h1FFFF, n + 1);
    push_exp(17'h00000, n + 2);
    do_arm(17'h1FFFE, 17'd3);
    wait_done("wrap_done", 40 * H);
    chk("wrap_frame_cnt", 64'(frame_cnt), 64'd3);

    // Zero-length take: immediate done, no writes
    @(posedge mclk);
    #1;
    do_arm(17'h00077, 17'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    req_seen = 1'b0;
    for (int i = 0; i < 5 * H; i++) begin
      @(negedge mclk);
      if (wr_req) req_seen = 1'b1;
    end
    chk("zero_no_req", 64'(req_seen), 64'd0);
    chk("zero_frame_cnt", 64'(frame_cnt), 64'd0);

    // Async reset with a write pending, then a normal take
    wr_ack = 1'b0;
    wait_half_mid(1'b0);
    do_arm(17'h00040, 17'd4);
    req_seen = 1'b0;
    for (int i = 0; i < 6 * H; i++) begin
      @(negedge mclk);
      if (wr_req) begin
        req_seen = 1'b1;
        break;
      end
    end
    chk("rst_req_seen", 64'(req_seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge mclk);
    #1;
    rst_n = 1'b1;
    wr_ack = 1'b1;
    wait_half_mid(1'b0);
    n = cur_frame;
    push_exp(17'h00050, n);
    push_exp(17'h00051, n + 1);
    do_arm(17'h00050, 17'd2);
    wait_done("post_rst_done", 40 * H);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd2);

    repeat (4) @(negedge mclk);
    chk("done_pulses", 64'(done_cnt), 64'd7);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_record_ctrl.md
# i2s_record_ctrl

Recording sequencer placed between the I2S receiver and the track sample memory. It watches the receiver's word-select output to find stereo frame boundaries and captures each completed left/right pair. While a take is armed or recording, it writes the pairs into memory through a request/acknowledge port at consecutive addresses. It also reports progress, completion and dropped frames to the transport logic.

## Interface
- WIDTH, 16: bits per channel sample; memory word is 2*WIDTH.
- ADDR_W, 17: memory address width; also the width of the length and counter fields.
- mclk  in  1  main clock, same clock that drives the receiver.
- rst_n  in  1  asynchronous, active-low reset (already decided).
- ws  in  1  word select from the receiver; 0 = left half, 1 = right half.
- rx_data_l  in  WIDTH  latest left sample from the receiver.
- rx_data_r  in  WIDTH  latest right sample from the receiver.
- arm  in  1  one-cycle pulse that starts a take.
- stop  in  1  one-cycle pulse that ends a take early.
- base_addr  in  ADDR_W  first write address; sampled on an accepted arm.
- rec_len  in  ADDR_W  number of frames in the take; sampled on an accepted arm.
- wr_req  out  1  a memory write is pending.
- wr_addr  out  ADDR_W  write address; stable while wr_req=1.
- wr_data  out  2*WIDTH  {left, right}; stable while wr_req=1.
- wr_ack  in  1  memory accepts the write in this cycle.
- busy  out  1  high in ARMED, RECORD and DRAIN.
- done  out  1  one-cycle pulse when a take ends.
- frame_cnt  out  ADDR_W  number of frames written in the current or last take.
- overrun  out  1  sticky flag, set when a frame is dropped; cleared on an accepted arm.

## Operation
- Frame detect: ws is registered into ws_d. A falling edge (ws_d=1, ws=0) seen at edge k marks a completed stereo frame. At edge k+2 the block latches {rx_data_l, rx_data_r} into the frame register and raises an internal frame_rdy strobe. The receiver updates its outputs one cycle after ws toggles, so both samples are stable by k+2.
- States:
  - IDLE: an arm latches base_addr and rec_len, clears frame_cnt and overrun, and moves to ARMED. If rec_len=0, the block instead pulses done and stays in IDLE with no writes.
  - ARMED: waits for the next frame_rdy, so recording always starts on a left-channel frame boundary. On frame_rdy the block asserts wr_req and moves to RECORD. A stop here returns to IDLE and pulses done.
  - RECORD: handles each frame_rdy (see write rules below). When frame_cnt reaches rec_len after an ack, the block goes to IDLE and pulses done. A stop with no write pending goes to IDLE and pulses done; a stop with a write pending goes to DRAIN.
  - DRAIN: ignores frame_rdy and waits for wr_ack. On the ack, frame_cnt increments, then the block goes to IDLE and pulses done.
- Write rules:
  - wr_addr = base + frame_cnt, taken modulo 2^ADDR_W so the address wraps silently.
  - wr_req stays asserted until the cycle in which wr_ack=1.
  - In that cycle frame_cnt increments and wr_req is cleared at the next edge, unless a new frame_rdy coincides.
  - A frame_rdy with no write pending loads wr_data and asserts wr_req.
  - A frame_rdy while a write is pending drops the new frame: overrun is set, and wr_data is not changed.
  - If frame_rdy and the ack occur in the same cycle, the ack completes the old write and the new frame is loaded, so wr_req stays high.
- An arm outside IDLE is ignored. A stop in IDLE is ignored. If arm and stop occur in the same cycle in IDLE, arm wins.
- Reset (including mid-take): the block returns to IDLE with wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_cnt=0, overrun=0, ws_d=0. Any outstanding write is abandoned.

## Timing
- Latency from the ws falling edge (seen at edge k) to wr_req=1 is 3 mclk edges: frame_rdy at k+2, wr_req registered at k+3.
- All outputs are registered. There is no combinational path from wr_ack to wr_req.
- done is asserted for exactly 1 cycle, in the same cycle that busy falls.
- At MAIN_TO_LEFT_RIGHT=1536, the memory may hold an ack for up to about 1530 cycles before a frame is dropped.

## Structure
- The shared package i2s_pkg holds:
  - the rec_state_t enum {IDLE, ARMED, RECORD, DRAIN};
  - the stereo_frame_t packed struct {left, right}.
- The package also holds the localparams common with the receiver: WIDTH and the clock ratios.
- Sub-module i2s_frame_sync contains ws_d, the edge detection, the two-cycle delay and the frame latch. It outputs frame_rdy and stereo_frame_t.

## Test plan
- Basic take: arm with base_addr=0x100 and rec_len=4, with wr_ack tied high. Expect 4 writes at 0x100–0x103 carrying the driven L/R values, then a done pulse and frame_cnt=4.
- Arm mid-frame: arm while ws=0 in the middle of a left half. Expect the first write to carry the frame that completes at the next ws fall, with no partial frame written.
- Backpressure: hold wr_ack low for 2000 cycles during the second frame. Expect wr_data unchanged, overrun=1, and the first frame written after release to be frame 2.
- Early stop: stop during a pending write, then ack 10 cycles later. Expect DRAIN, frame_cnt incremented once, then done; no further writes.
- Wrap and zero length:
  - base_addr=0x1FFFE with rec_len=3: expect writes at 0x1FFFE, 0x1FFFF, 0x00000.
  - rec_len=0: expect an immediate done pulse and no wr_req.
- Async reset mid-take: pulse rst_n low while wr_req=1. Expect all outputs at their reset values immediately, and normal operation on the next arm.
